// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between writeback (priority) and the MDU,
// with a forced one-cycle pipeline stall after STARVE_LIMIT consecutive MDU denials.
// Optional macro RF_ARB_STATS_EN adds the stall_count statistics port.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
`ifdef RF_ARB_STATS_EN
  output logic [15:0] stall_count,
`endif
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONTEND = 2'd1;
  localparam logic [1:0] ST_FORCE   = 2'd2;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  // Handshake: the MDU holds mdu_valid/addr/data until a cycle in which mdu_ready
  // is high; the request is consumed at the clock edge ending that cycle.

  logic [1:0] state, state_next;
  logic [3:0] starve_cnt, cnt_next, cnt_inc;
  logic       wb_act, grant_wb, grant_mdu, deny;

  always_comb begin
    wb_act     = wb_we && (wb_addr != 5'd0) && !pipe_stall;
    grant_wb   = 1'b0;
    grant_mdu  = 1'b0;
    if (state == ST_FORCE)
      grant_mdu = mdu_valid;
    else if (wb_act)
      grant_wb = 1'b1;
    else
      grant_mdu = mdu_valid;
    deny       = (state != ST_FORCE) && mdu_valid && wb_act;
    cnt_inc    = starve_cnt + 4'd1;
    state_next = state;
    cnt_next   = starve_cnt;
    case (state)
      ST_IDLE: begin
        if (deny) begin
          cnt_next   = 4'd1;
          state_next = (LIMIT == 4'd1) ? ST_FORCE : ST_CONTEND;
        end
      end
      ST_CONTEND: begin
        // Leaving CONTEND without a denial means either a grant or a dropped request.
        if (deny) begin
          cnt_next = cnt_inc;
          if (cnt_inc == LIMIT) state_next = ST_FORCE;
        end else begin
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  assign mdu_ready = grant_mdu && !rst;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= 4'd0;
      pipe_stall <= 1'b0;
      rf_we      <= 1'b0;
      rf_addr    <= 5'd0;
      rf_data    <= 32'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= cnt_next;
      pipe_stall <= (state_next == ST_FORCE);
      if (grant_wb) begin
        rf_we   <= 1'b1;
        rf_addr <= wb_addr;
        rf_data <= wb_data;
      end else if (grant_mdu) begin
        // An MDU result for r0 is consumed but never written.
        rf_we   <= (mdu_addr != 5'd0);
        rf_addr <= mdu_addr;
        rf_data <= mdu_data;
      end else begin
        rf_we   <= 1'b0;
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= 16'd0;
    else if ((state == ST_FORCE) && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a behavioural arbitration model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_regfile_write_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [1:0]  state_dbg;
`ifdef RF_ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
`ifdef RF_ARB_STATS_EN
    .stall_count(stall_count),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: counts consecutive MDU denials; the limit-th denial earns the
  // MDU a private write slot on the following cycle, during which writeback is stalled.
  bit          m_stall;
  int          m_denied;
  int          m_forces;
  bit          m_rf_we;
  logic [4:0]  m_rf_addr;
  logic [31:0] m_rf_data;
  logic [31:0] shadow_rf [32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stall = 0; m_denied = 0; m_forces = 0;
      m_rf_we = 0; m_rf_addr = 5'd0; m_rf_data = 32'd0;
    end else begin
      bit wb_eff;
      wb_eff = wb_we && (wb_addr != 5'd0) && !m_stall;
      if (m_stall) begin
        m_rf_we = mdu_valid && (mdu_addr != 5'd0);
        if (mdu_valid) begin m_rf_addr = mdu_addr; m_rf_data = mdu_data; end
        m_stall = 0; m_denied = 0; m_forces++;
      end else if (wb_eff) begin
        m_rf_we = 1; m_rf_addr = wb_addr; m_rf_data = wb_data;
        if (mdu_valid) begin
          m_denied++;
          if (m_denied >= LIMIT) begin m_stall = 1; m_denied = 0; end
        end else begin
          m_denied = 0;
        end
      end else begin
        m_denied = 0;
        m_rf_we = mdu_valid && (mdu_addr != 5'd0);
        if (mdu_valid) begin m_rf_addr = mdu_addr; m_rf_data = mdu_data; end
      end
    end
  end

  always @(posedge clk) if (rf_we) shadow_rf[rf_addr] <= rf_data;

  // scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      bit exp_ready;
      exp_ready = m_stall ? mdu_valid : (mdu_valid && !(wb_we && wb_addr != 5'd0));
      chk("model_mdu_ready", 32'(mdu_ready), 32'(exp_ready));
      chk("model_pipe_stall", 32'(pipe_stall), 32'(m_stall));
      chk("model_rf_we", 32'(rf_we), 32'(m_rf_we));
      if (m_rf_we) begin
        chk("model_rf_addr", 32'(rf_addr), 32'(m_rf_addr));
        chk("model_rf_data", rf_data, m_rf_data);
      end
`ifdef RF_ARB_STATS_EN
      chk("model_stall_count", 32'(stall_count), 32'(m_forces));
`endif
    end
  end

  // driver: present inputs for one cycle, report mdu_ready/pipe_stall seen mid-cycle
  logic got_ready, got_stall;
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we = we; wb_addr = wa; wb_data = wd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    @(negedge clk);
    got_ready = mdu_ready;
    got_stall = pipe_stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_we = 0; wb_addr = 0; wb_data = 0; mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // asynchronous reset mid-cycle clears outputs before any edge
    step(1, 5'd2, 32'h11, 0, 0, 0);
    chk("pre_reset_rf_we", 32'(rf_we), 32'd1);
    mdu_valid = 1; mdu_addr = 5'd7; mdu_data = 32'hDEADBEEF; wb_we = 0;
    #2 rst = 1'b1;
    #1;
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_rf_addr", 32'(rf_addr), 32'd0);
    chk("reset_rf_data", rf_data, 32'd0);
    chk("reset_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("reset_mdu_ready", 32'(mdu_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // lone MDU write
    step(0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
    chk("lone_mdu_ready", 32'(got_ready), 32'd1);
    chk("lone_rf_we", 32'(rf_we), 32'd1);
    chk("lone_rf_addr", 32'(rf_addr), 32'd7);
    chk("lone_rf_data", rf_data, 32'hDEADBEEF);

    // contention: four denials, then a forced stall slot
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd3, 32'hA0 + 32'(i), 1, 5'd5, 32'h5555);
      chk("contend_denied", 32'(got_ready), 32'd0);
      chk("contend_no_stall", 32'(got_stall), 32'd0);
    end
    step(1, 5'd3, 32'hA4, 1, 5'd5, 32'h5555);
    chk("force_stall", 32'(got_stall), 32'd1);
    chk("force_ready", 32'(got_ready), 32'd1);
    chk("force_rf_addr", 32'(rf_addr), 32'd5);
    chk("force_rf_data", rf_data, 32'h5555);
    step(1, 5'd3, 32'hA4, 0, 0, 0);
    chk("represent_no_stall", 32'(got_stall), 32'd0);
    chk("represent_rf_addr", 32'(rf_addr), 32'd3);
    chk("represent_rf_data", rf_data, 32'hA4);
`ifdef RF_ARB_STATS_EN
    chk("stall_count_one", 32'(stall_count), 32'd1);
`endif

    // r0 filtering
    step(1, 5'd0, 32'hF0, 1, 5'd9, 32'h9999);
    chk("r0wb_mdu_ready", 32'(got_ready), 32'd1);
    chk("r0wb_rf_addr", 32'(rf_addr), 32'd9);
    chk("r0wb_rf_we", 32'(rf_we), 32'd1);
    step(0, 0, 0, 1, 5'd0, 32'h1234);
    chk("r0mdu_ready", 32'(got_ready), 32'd1);
    chk("r0mdu_rf_we", 32'(rf_we), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // same-address collision: writeback first, MDU lands later
    step(1, 5'd12, 32'hAAAA, 1, 5'd12, 32'hBBBB);
    chk("coll_denied", 32'(got_ready), 32'd0);
    chk("coll_wb_data", rf_data, 32'hAAAA);
    step(0, 0, 0, 1, 5'd12, 32'hBBBB);
    chk("coll_mdu_ready", 32'(got_ready), 32'd1);
    chk("coll_mdu_data", rf_data, 32'hBBBB);
    step(0, 0, 0, 0, 0, 0);
    chk("coll_final_r12", shadow_rf[12], 32'hBBBB);

    // reset during the forced slot
    for (int i = 0; i < 4; i++) step(1, 5'd4, 32'hC0, 1, 5'd6, 32'h6666);
    wb_we = 1; wb_addr = 5'd4; wb_data = 32'hC0;
    mdu_valid = 1; mdu_addr = 5'd6; mdu_data = 32'h6666;
    #1;
    chk("rf_force_stall", 32'(pipe_stall), 32'd1);
    chk("rf_force_ready", 32'(mdu_ready), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rf_reset_stall", 32'(pipe_stall), 32'd0);
    chk("rf_reset_ready", 32'(mdu_ready), 32'd0);
`ifdef RF_ARB_STATS_EN
    chk("rf_reset_stall_count", 32'(stall_count), 32'd0);
`endif
    wb_we = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(0, 0, 0, 1, 5'd6, 32'h6666);
    chk("post_reset_ready", 32'(got_ready), 32'd1);
    chk("post_reset_rf_addr", 32'(rf_addr), 32'd6);
    chk("post_reset_rf_data", rf_data, 32'h6666);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
